// File: rtl/pe_result_drain.sv
// Snapshots one row of PE results on start and streams them out one word per cycle
// over valid/ready. Optional DRAIN_RELU_EN zeroes negative words at capture.

module pe_drain_lane #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!reset) q <= '0;
    else if (load) begin
`ifdef DRAIN_RELU_EN
      q <= d[DATA_W-1] ? '0 : d;
`else
      q <= d;
`endif
    end
  end
endmodule

module pe_result_drain #(
  parameter int N_PE   = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(N_PE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N_PE*DATA_W-1:0] pe_result,
  output logic                   capture_ack,
  output logic                   busy,
  output logic [DATA_W-1:0]      out_data,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   done
);
  typedef enum logic [1:0] {IDLE, CAPTURED, STREAM, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PE - 1);

  state_t                        state;
  logic [IDX_W-1:0]              idx, idx_nxt;
  logic [N_PE-1:0][DATA_W-1:0]   pe_vec, shadow;
  logic                          load;

  assign pe_vec  = pe_result;
  assign load    = (state == IDLE) && start;
  assign idx_nxt = idx + IDX_W'(1);

  for (genvar k = 0; k < N_PE; k++) begin : g_lane
    pe_drain_lane #(.DATA_W(DATA_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .d     (pe_vec[k]),
      .q     (shadow[k])
    );
  end

  // Outputs are registered alongside the state, so each transition loads the
  // values the next state presents; out_data is prefetched from shadow[idx+1].
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      capture_ack <= 1'b0;
      busy        <= 1'b0;
      out_data    <= '0;
      out_idx     <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= CAPTURED;
            idx         <= '0;
            capture_ack <= 1'b1;
            busy        <= 1'b1;
          end
        end
        CAPTURED: begin
          state       <= STREAM;
          capture_ack <= 1'b0;
          out_valid   <= 1'b1;
          out_data    <= shadow[0];
          out_idx     <= '0;
          out_last    <= (LAST_IDX == '0);
        end
        STREAM: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              state     <= DONE;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_idx   <= '0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx      <= idx_nxt;
              out_data <= shadow[idx_nxt];
              out_idx  <= idx_nxt;
              out_last <= (idx_nxt == LAST_IDX);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          idx   <= '0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain: cycle tables for basic drain and backpressure,
// plus sequences for snapshot isolation, start-while-busy, mid-stream reset, back-to-back.

module tb_pe_result_drain;
  localparam int N_PE = 4, DATA_W = 32, IDX_W = 2;

`ifdef DRAIN_RELU_EN
  localparam logic [31:0] M3 = 32'd0;
`else
  localparam logic [31:0] M3 = 32'hFFFF_FFFD;
`endif
  localparam logic [127:0] P = {32'd40, 32'hFFFF_FFFD, 32'd7, 32'd100};

  logic                   clk = 1'b0;
  logic                   reset, start, out_ready;
  logic [N_PE*DATA_W-1:0] pe_result;
  logic                   capture_ack, busy, out_valid, out_last, done;
  logic [DATA_W-1:0]      out_data;
  logic [IDX_W-1:0]       out_idx;

  int tests = 0, fails = 0;

  pe_result_drain #(.N_PE(N_PE), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .pe_result(pe_result),
    .capture_ack(capture_ack), .busy(busy), .out_data(out_data), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start, rdy;
    logic        ack, busy, vld;
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last, done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic r, logic a, logic b, logic v,
                              logic [31:0] d, logic [1:0] i, logic l, logic dn);
    vec_t x;
    x.start = s; x.rdy = r; x.ack = a; x.busy = b; x.vld = v;
    x.data = d; x.idx = i; x.last = l; x.done = dn;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Run one drain with out_ready high; checks ack latency, words, out_last and done latency.
  task automatic drain(string nm, logic [3:0][31:0] exp, bit scramble);
    int c, n;
    bit got_done;
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, " ack"}, 32'(capture_ack), 32'd1);
    if (scramble) pe_result = {4{32'hDEAD_BEEF}};
    c = 1; n = 0; got_done = 0;
    for (int t = 0; t < 20 && !got_done; t++) begin
      tick(); c++;
      if (out_valid) begin
        if (n < 4) begin
          chk($sformatf("%s data%0d", nm, n), out_data, exp[n]);
          chk($sformatf("%s idx%0d", nm, n), 32'(out_idx), n);
          chk($sformatf("%s last%0d", nm, n), 32'(out_last), 32'(n == 3));
        end
        n++;
      end
      if (done) got_done = 1;
    end
    chk({nm, " done seen"}, 32'(got_done), 32'd1);
    chk({nm, " done latency"}, c, 6);
    chk({nm, " words"}, n, 4);
  endtask

  initial begin
    int words, dones, acks;
    bit hit;
    reset = 1'b0; start = 1'b0; out_ready = 1'b1; pe_result = '0;
    tick(); tick();
    chk("rst busy", 32'(busy), 0);
    chk("rst vld", 32'(out_valid), 0);
    chk("rst ack", 32'(capture_ack), 0);
    chk("rst done", 32'(done), 0);
    chk("rst data", out_data, 0);
    chk("rst idx", 32'(out_idx), 0);
    reset = 1'b1;
    tick();

    // Basic drain: each row = inputs before an edge, outputs just after it.
    vecs.push_back(mk(1,1, 1,1,0, 0,   0,0,0));
    vecs.push_back(mk(0,1, 0,1,1, 100, 0,0,0));
    vecs.push_back(mk(0,1, 0,1,1, 7,   1,0,0));
    vecs.push_back(mk(0,1, 0,1,1, M3,  2,0,0));
    vecs.push_back(mk(0,1, 0,1,1, 40,  3,1,0));
    vecs.push_back(mk(0,1, 0,1,0, 0,   0,0,1));
    vecs.push_back(mk(0,1, 0,0,0, 0,   0,0,0));
    // Backpressure: three stalled edges at idx 1, done three cycles later.
    vecs.push_back(mk(1,1, 1,1,0, 0,   0,0,0));
    vecs.push_back(mk(0,1, 0,1,1, 100, 0,0,0));
    vecs.push_back(mk(0,1, 0,1,1, 7,   1,0,0));
    vecs.push_back(mk(0,0, 0,1,1, 7,   1,0,0));
    vecs.push_back(mk(0,0, 0,1,1, 7,   1,0,0));
    vecs.push_back(mk(0,0, 0,1,1, 7,   1,0,0));
    vecs.push_back(mk(0,1, 0,1,1, M3,  2,0,0));
    vecs.push_back(mk(0,1, 0,1,1, 40,  3,1,0));
    vecs.push_back(mk(0,1, 0,1,0, 0,   0,0,1));
    vecs.push_back(mk(0,1, 0,0,0, 0,   0,0,0));

    pe_result = P;
    foreach (vecs[i]) begin
      start = vecs[i].start; out_ready = vecs[i].rdy;
      tick();
      chk($sformatf("v%0d ack", i),  32'(capture_ack), 32'(vecs[i].ack));
      chk($sformatf("v%0d busy", i), 32'(busy),        32'(vecs[i].busy));
      chk($sformatf("v%0d vld", i),  32'(out_valid),   32'(vecs[i].vld));
      chk($sformatf("v%0d data", i), out_data,         vecs[i].data);
      chk($sformatf("v%0d idx", i),  32'(out_idx),     32'(vecs[i].idx));
      chk($sformatf("v%0d last", i), 32'(out_last),    32'(vecs[i].last));
      chk($sformatf("v%0d done", i), 32'(done),        32'(vecs[i].done));
    end
    start = 1'b0; out_ready = 1'b1;

    // Snapshot isolation: PE inputs scrambled right after capture_ack.
    pe_result = P;
    drain("iso", {32'd40, M3, 32'd7, 32'd100}, 1'b1);
    tick();

    // Start pulses during STREAM and during the DONE cycle are both dropped.
    pe_result = {32'd4, 32'd3, 32'd2, 32'd1};
    start = 1'b1;
    tick();
    start = 1'b0;
    words = 0; dones = 0; acks = 0;
    for (int t = 0; t < 15; t++) begin
      start = (out_valid && out_idx == 2'd1) || done;
      tick();
      if (out_valid) words++;
      if (done) dones++;
      if (capture_ack) acks++;
    end
    start = 1'b0;
    chk("busy-start words", words, 4);
    chk("busy-start dones", dones, 1);
    chk("busy-start acks", acks, 0);
    chk("busy-start idle", 32'(busy), 0);

    // Reset while streaming idx 2: no done, then a fresh drain.
    pe_result = P;
    start = 1'b1;
    tick();
    start = 1'b0;
    hit = 0;
    for (int t = 0; t < 10 && !hit; t++) begin
      tick();
      if (out_valid && out_idx == 2'd2) hit = 1;
    end
    chk("rst-mid reached idx2", 32'(hit), 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst-mid vld", 32'(out_valid), 0);
    chk("rst-mid busy", 32'(busy), 0);
    chk("rst-mid done", 32'(done), 0);
    chk("rst-mid idx", 32'(out_idx), 0);
    pe_result = {32'd8, 32'd7, 32'd6, 32'd5};
    drain("after-rst", {32'd8, 32'd7, 32'd6, 32'd5}, 1'b0);

    // Back-to-back: second start in the first IDLE cycle after done.
    tick();
    pe_result = {32'd11, 32'hFFFF_FF00, 32'd22, 32'd33};
`ifdef DRAIN_RELU_EN
    drain("b2b", {32'd11, 32'd0, 32'd22, 32'd33}, 1'b0);
`else
    drain("b2b", {32'd11, 32'hFFFF_FF00, 32'd22, 32'd33}, 1'b0);
`endif
    tick();
    chk("b2b idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
